// File: rtl/mlp_feature_sequencer.sv
// mlp_feature_sequencer
//   Sequential front-end for the combinational printed-MLP `top`. Collects
//   NUM_A feature samples over a valid/ready input and packs them into the
//   flattened classifier input vector. It holds that vector for SETTLE_CYCLES,
//   then captures the classifier result and offers it on a valid/ready output.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   s_valid/s_ready     feature sample handshake, s_data = sample (unsigned)
//   mlp_inp             flattened feature vector driven to top.inp
//   mlp_out             classifier result from top.out (sampled only at capture)
//   m_valid/m_ready     result handshake, m_class = captured result
//   busy                high while settling or presenting a result
//
// Optional feature (macro MLP_LABEL_CHECK_EN)
//   s_label             expected class, registered with the last feature
//   m_match             m_class equals the registered label
//   correct_cnt         saturating count of matching delivered results
//   total_cnt           saturating count of delivered results
module mlp_feature_sequencer #(
    parameter int unsigned NUM_A         = 4,
    parameter int unsigned WIDTH_A       = 4,
    parameter int unsigned OUTWIDTH      = 2,
    parameter int unsigned SETTLE_CYCLES = 3,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [WIDTH_A-1:0]         s_data,
    output logic [NUM_A*WIDTH_A-1:0]   mlp_inp,
    input  logic [OUTWIDTH-1:0]        mlp_out,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [OUTWIDTH-1:0]        m_class,
    output logic                       busy
`ifdef MLP_LABEL_CHECK_EN
    ,
    input  logic [OUTWIDTH-1:0]        s_label,
    output logic                       m_match,
    output logic [CNT_W-1:0]           correct_cnt,
    output logic [CNT_W-1:0]           total_cnt
`endif
);

    localparam int unsigned IDX_W = (NUM_A > 1) ? $clog2(NUM_A) : 1;
    localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_A - 1);
    localparam logic [SET_W-1:0] SET_START = SET_W'(SETTLE_CYCLES - 1);

    // Reject parameter sets the datapath cannot represent.
    if (NUM_A < 1 || SETTLE_CYCLES < 1 || CNT_W < 1) begin : g_param_check
        $error("mlp_feature_sequencer: NUM_A, SETTLE_CYCLES and CNT_W must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_OUT    = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic [SET_W-1:0] cnt;
    logic             in_xfer;
    logic             out_xfer;
    logic             capture;

    // s_ready is a decode of the state register, gated so it stays low in reset.
    assign s_ready  = (state == ST_LOAD) && !rst;
    assign in_xfer  = s_valid && s_ready;
    assign out_xfer = m_valid && m_ready;
    assign capture  = (state == ST_SETTLE) && (cnt == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_LOAD:   if (in_xfer && (idx == IDX_LAST)) state_next = ST_SETTLE;
            ST_SETTLE: if (cnt == '0)                    state_next = ST_OUT;
            ST_OUT:    if (out_xfer)                     state_next = ST_LOAD;
            default:                                     state_next = ST_LOAD;
        endcase
    end

    // Feature assembly, settle counter and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            cnt     <= '0;
            mlp_inp <= '0;
            m_class <= '0;
            m_valid <= 1'b0;
            busy    <= 1'b0;
        end else begin
            busy <= (state_next != ST_LOAD);
            if (in_xfer) begin
                // Only the addressed slice is rewritten; others keep the old vector.
                for (int unsigned i = 0; i < NUM_A; i++) begin
                    if (idx == IDX_W'(i)) begin
                        mlp_inp[i*WIDTH_A +: WIDTH_A] <= s_data;
                    end
                end
                if (idx == IDX_LAST) begin
                    idx <= '0;
                    cnt <= SET_START;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
            if (state == ST_SETTLE && cnt != '0) begin
                cnt <= cnt - SET_W'(1);
            end
            if (capture) begin
                m_class <= mlp_out;
                m_valid <= 1'b1;
            end else if (out_xfer) begin
                m_valid <= 1'b0;
            end
        end
    end

`ifdef MLP_LABEL_CHECK_EN
    logic [OUTWIDTH-1:0] label_q;

    // Label capture, match flag and saturating statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            label_q     <= '0;
            m_match     <= 1'b0;
            correct_cnt <= '0;
            total_cnt   <= '0;
        end else begin
            if (in_xfer && (idx == IDX_LAST)) begin
                label_q <= s_label;
            end
            if (capture) begin
                m_match <= (mlp_out == label_q);
            end
            if (out_xfer) begin
                if (total_cnt != '1) begin
                    total_cnt <= total_cnt + CNT_W'(1);
                end
                if (m_match && (correct_cnt != '1)) begin
                    correct_cnt <= correct_cnt + CNT_W'(1);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_mlp_feature_sequencer.sv
// Directed self-checking bench for mlp_feature_sequencer (default parameters).
module tb_mlp_feature_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [3:0]  s_data;
    logic [15:0] mlp_inp;
    logic [1:0]  mlp_out;
    logic        m_valid;
    logic        m_ready;
    logic [1:0]  m_class;
    logic        busy;
`ifdef MLP_LABEL_CHECK_EN
    logic [1:0]  s_label = 2'd0;
    logic        m_match;
    logic [15:0] correct_cnt;
    logic [15:0] total_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mlp_feature_sequencer #(
        .NUM_A(4), .WIDTH_A(4), .OUTWIDTH(2), .SETTLE_CYCLES(3), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .mlp_inp(mlp_inp), .mlp_out(mlp_out),
        .m_valid(m_valid), .m_ready(m_ready), .m_class(m_class),
        .busy(busy)
`ifdef MLP_LABEL_CHECK_EN
        , .s_label(s_label), .m_match(m_match),
        .correct_cnt(correct_cnt), .total_cnt(total_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int pulses;
    int first_pulse;
    int last_pulse;
    int bad_gap;
    int wide;
    logic prev_valid;

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = 4'd0; mlp_out = 2'd0; m_ready = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_mlp_inp", 32'(mlp_inp), 32'h0);
        chk("rst_m_class", 32'(m_class), 32'd0);
        rst = 1'b0;
        #1;
        chk("load_s_ready", 32'(s_ready), 32'd1);

        // Basic: 3,7,1,15 back-to-back, mlp_out=2
        mlp_out = 2'd2;
        s_valid = 1'b1;
        s_data = 4'd3;  tick();
        s_data = 4'd7;  tick();
        s_data = 4'd1;  tick();
        s_data = 4'd15; tick();
        // junk samples offered while not in LOAD must be ignored
        s_data = 4'd9;
        chk("basic_vec",     32'(mlp_inp), 32'hF173);
        chk("basic_busy",    32'(busy),    32'd1);
        chk("basic_s_ready", 32'(s_ready), 32'd0);
        chk("basic_mv_s1",   32'(m_valid), 32'd0);
        tick();
        chk("basic_mv_s2",   32'(m_valid), 32'd0);
        chk("basic_frozen2", 32'(mlp_inp), 32'hF173);
        tick();
        chk("basic_mv_s3",   32'(m_valid), 32'd0);
        chk("basic_frozen3", 32'(mlp_inp), 32'hF173);
        tick();
        chk("basic_mv_out",  32'(m_valid), 32'd1);
        chk("basic_class",   32'(m_class), 32'd2);

        // Back-pressure: hold m_ready low 10 cycles while mlp_out changes
        mlp_out = 2'd1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_m_valid", 32'(m_valid), 32'd1);
            chk("bp_m_class", 32'(m_class), 32'd2);
            chk("bp_s_ready", 32'(s_ready), 32'd0);
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("bp_release_mv",  32'(m_valid), 32'd0);
        chk("bp_release_rdy", 32'(s_ready), 32'd1);
        chk("bp_release_bsy", 32'(busy),    32'd0);
        chk("bp_keep_vec",    32'(mlp_inp), 32'hF173);

        // Reset in the second SETTLE cycle discards the pending vector
        mlp_out = 2'd3;
        s_valid = 1'b1;
        s_data = 4'd5; tick();
        s_data = 4'd6; tick();
        s_data = 4'd7; tick();
        s_data = 4'd8; tick();
        s_valid = 1'b0;
        chk("rs_vec", 32'(mlp_inp), 32'h8765);
        tick();
        rst = 1'b1;
        tick();
        chk("rs_m_valid", 32'(m_valid), 32'd0);
        chk("rs_mlp_inp", 32'(mlp_inp), 32'h0);
        chk("rs_busy",    32'(busy),    32'd0);
        chk("rs_s_ready", 32'(s_ready), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rs_no_result", 32'(m_valid), 32'd0);
        end

        // Gapped input: bubbles between features, m_ready held high
        mlp_out = 2'd2;
        m_ready = 1'b1;
        s_valid = 1'b0; tick();
        chk("gap_bubble0", 32'(mlp_inp), 32'h0);
        s_valid = 1'b1; s_data = 4'd3; tick();
        chk("gap_f0", 32'(mlp_inp), 32'h0003);
        s_valid = 1'b0; tick(); tick();
        chk("gap_bubble1", 32'(mlp_inp), 32'h0003);
        chk("gap_ready",   32'(s_ready), 32'd1);
        s_valid = 1'b1; s_data = 4'd7; tick();
        chk("gap_f1", 32'(mlp_inp), 32'h0073);
        s_valid = 1'b0; tick();
        s_valid = 1'b1; s_data = 4'd1; tick();
        chk("gap_f2", 32'(mlp_inp), 32'h0173);
        s_valid = 1'b0; tick();
        s_valid = 1'b1; s_data = 4'd15; tick();
        s_valid = 1'b0;
        chk("gap_vec", 32'(mlp_inp), 32'hF173);
        tick();
        chk("gap_mv_s2", 32'(m_valid), 32'd0);
        tick();
        chk("gap_mv_s3", 32'(m_valid), 32'd0);
        tick();
        chk("gap_mv_out", 32'(m_valid), 32'd1);
        chk("gap_class",  32'(m_class), 32'd2);
        tick();
        chk("gap_done",   32'(m_valid), 32'd0);
        chk("gap_ready2", 32'(s_ready), 32'd1);

        // Throughput: continuous traffic, one result per 8 cycles
        pulses = 0; first_pulse = -1; last_pulse = -1; bad_gap = 0; wide = 0;
        prev_valid = 1'b0;
        s_valid = 1'b1; s_data = 4'd4;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (m_valid && !prev_valid) begin
                pulses++;
                if (first_pulse < 0) first_pulse = i;
                if (last_pulse >= 0 && (i - last_pulse) != 8) bad_gap++;
                last_pulse = i;
            end
            if (m_valid && prev_valid) wide++;
            prev_valid = m_valid;
        end
        s_valid = 1'b0;
        tick();
        chk("tp_pulses",   32'(pulses),      32'd5);
        chk("tp_first",    32'(first_pulse), 32'd7);
        chk("tp_gaps",     32'(bad_gap),     32'd0);
        chk("tp_width",    32'(wide),        32'd0);
        chk("tp_vec",      32'(mlp_inp),     32'h4444);
        chk("tp_drained",  32'(m_valid),     32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mlp_feature_sequencer.md
Name: mlp_feature_sequencer

Overview:
- Sequential front-end for the combinational printed-MLP `top`.
- Accepts ADC feature samples one per handshake and assembles them into the flattened `inp` vector.
- Holds that vector stable for a programmable settle time, then captures the classifier output and presents it on a valid/ready result port.
- Replaces the free-running per-vector hold with a cycle-accurate, back-pressured pipeline stage.
- Optionally checks results against a supplied label and counts correct inferences.

Parameters:
- NUM_A, 4, number of features per inference vector (>=1).
- WIDTH_A, 4, bits per feature.
- OUTWIDTH, 2, bits of the classifier output.
- SETTLE_CYCLES, 3, clock cycles the assembled vector is held before capture (>=1).
- CNT_W, 16, width of the statistics counters (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  feature sample valid.
- s_ready  out  1  sequencer can accept a feature.
- s_data  in  WIDTH_A  feature sample, unsigned.
- mlp_inp  out  NUM_A*WIDTH_A  flattened feature vector to `top.inp`.
- mlp_out  in  OUTWIDTH  classifier result from `top.out`.
- m_valid  out  1  result valid.
- m_ready  in  1  result consumer ready.
- m_class  out  OUTWIDTH  captured classifier result.
- busy  out  1  high in SETTLE or OUT.

Behaviour:
- Reset values:
  - state=LOAD, feature index idx=0, settle counter=0.
  - mlp_inp=0, m_class=0, m_valid=0, busy=0.
  - s_ready=0 while rst is high.
- Handshakes:
  - Input transfer occurs when s_valid&&s_ready at a rising edge.
  - Output transfer occurs when m_valid&&m_ready.
- State machine (three states):
  - LOAD: s_ready=1, busy=0. On an input transfer, s_data is written to slice [(idx+1)*WIDTH_A-1 : idx*WIDTH_A] of mlp_inp and idx increments.
    - A transfer at idx==NUM_A-1 clears idx to 0, loads the counter with SETTLE_CYCLES-1, and moves to SETTLE.
    - Slices not yet rewritten keep their previous value.
  - SETTLE: s_ready=0, busy=1, mlp_inp frozen.
    - Counter decrements each cycle.
    - On the cycle the counter==0: m_class<=mlp_out, m_valid<=1, go to OUT.
  - OUT: s_ready=0, busy=1. m_valid and m_class are held stable until m_ready.
    - On an output transfer: m_valid<=0, go to LOAD.
    - mlp_inp keeps its value until overwritten in LOAD.
- Latency and throughput:
  - Last feature accepted at edge t: SETTLE occupies cycles t+1 .. t+SETTLE_CYCLES, and m_valid is first high in cycle t+SETTLE_CYCLES+1.
  - With m_ready held at 1, throughput is one result per NUM_A+SETTLE_CYCLES+1 cycles.
- Boundaries:
  - NUM_A=1: every input transfer starts SETTLE.
  - SETTLE_CYCLES=1: capture happens in the single SETTLE cycle.
  - m_ready high while m_valid is low has no effect.
  - s_valid is ignored outside LOAD; the upstream source must hold data, since no sample is dropped silently.
  - rst asserted mid-operation (any state) returns to reset values at the next edge; any partial vector or pending result is discarded.
  - mlp_out is sampled only at capture; changes at any other time are ignored.

Optional Feature:
- Macro: MLP_LABEL_CHECK_EN.
- When defined, add these ports:
  - s_label  in  OUTWIDTH  expected class.
  - m_match  out  1  m_class equals the captured label.
  - correct_cnt  out  CNT_W  count of matching results.
  - total_cnt  out  CNT_W  count of delivered results.
- When defined, the behaviour is:
  - s_label is registered on the transfer of the last feature.
  - m_match is computed at capture and held with m_class.
  - On each output transfer, total_cnt increments and correct_cnt increments if m_match.
  - Both counters saturate at all-ones and reset to 0.
- When not defined: these ports and registers do not exist, and the core behaviour is identical.

Test Plan (NUM_A=4, WIDTH_A=4, OUTWIDTH=2, SETTLE_CYCLES=3):
- Basic: stream 3,7,1,15 back-to-back with mlp_out=2 -> mlp_inp=16'hF173 frozen 3 cycles; m_valid rises 4 cycles after the last transfer; m_class=2.
- Back-pressure: hold m_ready=0 for 10 cycles in OUT while mlp_out changes to 1 -> m_class stays 2, s_ready=0 throughout; after m_ready=1 for one edge, the sequencer returns to LOAD and s_ready=1.
- Gapped input: insert s_valid=0 bubbles between features -> idx advances only on transfers, and the same vector and latency as the basic case result.
- Reset mid-SETTLE: assert rst for one cycle in the second SETTLE cycle -> m_valid=0, mlp_inp=0, idx=0; the next 4 features form a fresh vector.
- Throughput: continuous s_valid=1 and m_ready=1 for 5 vectors -> exactly one m_valid pulse every 8 cycles.
- With MLP_LABEL_CHECK_EN: 4 vectors with labels 2,1,0,3 against mlp_out 2,2,0,0 -> m_match=1,0,1,0; final correct_cnt=2, total_cnt=4.
